// File: rtl/modaddsub_pkg.sv
// rtl/modaddsub_pkg.sv - shared types and latency helper for the modular add/sub pipeline
package modaddsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic ff_in;
    logic ff_add;
    logic ff_out;
  } stage_flags_t;

  function automatic int modaddsub_lat(input stage_flags_t f);
    return int'(f.ff_in) + int'(f.ff_add) + int'(f.ff_out);
  endfunction

endpackage

// File: rtl/modaddsub_lane.sv
// rtl/modaddsub_lane.sv - per-lane modular add/sub datapath, split at the add/output stage boundary
module modaddsub_lane
  import modaddsub_pkg::*;
#(
  parameter int LOGQ = 64
) (
  input  logic            i_op,
  input  logic [LOGQ-1:0] i_q,
  input  logic [LOGQ-1:0] i_a,
  input  logic [LOGQ-1:0] i_b,
  output logic [LOGQ-1:0] o_raw,
  output logic [LOGQ-1:0] o_corr,
  output logic            o_use_corr,
  input  logic [LOGQ-1:0] i_raw,
  input  logic [LOGQ-1:0] i_corr,
  input  logic            i_use_corr,
  output logic [LOGQ-1:0] o_c
);

  logic [LOGQ:0] w_sum;
  logic          w_sum_ge_q;
  logic          w_a_lt_b;

  assign w_sum      = {1'b0, i_a} + {1'b0, i_b};
  assign w_sum_ge_q = (w_sum >= {1'b0, i_q});
  assign w_a_lt_b   = (i_a < i_b);

  // Only the low LOGQ bits of R-q and D+q survive, so they are formed modulo 2^LOGQ;
  // the sign tests are done as magnitude compares instead.
  always_comb begin
    o_raw      = w_sum[LOGQ-1:0];
    o_corr     = w_sum[LOGQ-1:0] - i_q;
    o_use_corr = w_sum_ge_q;
    if (op_e'(i_op) == OP_SUB) begin
      o_raw      = i_a - i_b;
      o_corr     = i_a - i_b + i_q;
      o_use_corr = w_a_lt_b;
    end
  end

  assign o_c = i_use_corr ? i_corr : i_raw;

endmodule

// File: rtl/modaddsub_pipe.sv
// rtl/modaddsub_pipe.sv - multi-lane pipelined modular adder/subtractor with global-enable flow control
module modaddsub_pipe
  import modaddsub_pkg::*;
#(
  parameter int LOGQ   = 64,
  parameter int LANES  = 4,
  parameter int TAGW   = 8,
  parameter int FF_IN  = 1,
  parameter int FF_ADD = 1,
  parameter int FF_OUT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_op,
  input  logic [LOGQ-1:0]       in_q,
  input  logic [LANES*LOGQ-1:0] in_a,
  input  logic [LANES*LOGQ-1:0] in_b,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LOGQ-1:0] out_c,
  output logic [TAGW-1:0]       out_tag
);

  localparam int W = LANES * LOGQ;
  localparam stage_flags_t STAGES = '{ff_in: (FF_IN != 0), ff_add: (FF_ADD != 0), ff_out: (FF_OUT != 0)};
  localparam int LAT = modaddsub_lat(STAGES);

  logic            w_en;
  logic            w_s0_valid, w_s0_op;
  logic [LOGQ-1:0] w_s0_q;
  logic [W-1:0]    w_s0_a, w_s0_b;
  logic [TAGW-1:0] w_s0_tag;
  logic [W-1:0]    w_add_raw, w_add_corr;
  logic [LANES-1:0] w_add_sel;
  logic            w_s1_valid;
  logic [W-1:0]    w_s1_raw, w_s1_corr;
  logic [LANES-1:0] w_s1_sel;
  logic [TAGW-1:0] w_s1_tag;
  logic [W-1:0]    w_c;

  // Every stage advances together; a held output stalls the whole pipe, bubbles included.
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = (LAT == 0) ? out_ready : w_en;

  generate
    if (FF_IN != 0) begin : g_ff_in
      logic            r_valid, r_op;
      logic [LOGQ-1:0] r_q;
      logic [W-1:0]    r_a, r_b;
      logic [TAGW-1:0] r_tag;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_op    <= 1'b0;
          r_q     <= '0;
          r_a     <= '0;
          r_b     <= '0;
          r_tag   <= '0;
        end else if (w_en) begin
          r_valid <= in_valid;
          r_op    <= in_op;
          r_q     <= in_q;
          r_a     <= in_a;
          r_b     <= in_b;
          r_tag   <= in_tag;
        end
      end
      assign w_s0_valid = r_valid;
      assign w_s0_op    = r_op;
      assign w_s0_q     = r_q;
      assign w_s0_a     = r_a;
      assign w_s0_b     = r_b;
      assign w_s0_tag   = r_tag;
    end else begin : g_no_ff_in
      assign w_s0_valid = in_valid;
      assign w_s0_op    = in_op;
      assign w_s0_q     = in_q;
      assign w_s0_a     = in_a;
      assign w_s0_b     = in_b;
      assign w_s0_tag   = in_tag;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
      modaddsub_lane #(.LOGQ(LOGQ)) u_lane (
        .i_op       (w_s0_op),
        .i_q        (w_s0_q),
        .i_a        (w_s0_a[i*LOGQ +: LOGQ]),
        .i_b        (w_s0_b[i*LOGQ +: LOGQ]),
        .o_raw      (w_add_raw[i*LOGQ +: LOGQ]),
        .o_corr     (w_add_corr[i*LOGQ +: LOGQ]),
        .o_use_corr (w_add_sel[i]),
        .i_raw      (w_s1_raw[i*LOGQ +: LOGQ]),
        .i_corr     (w_s1_corr[i*LOGQ +: LOGQ]),
        .i_use_corr (w_s1_sel[i]),
        .o_c        (w_c[i*LOGQ +: LOGQ])
      );
    end

    if (FF_ADD != 0) begin : g_ff_add
      logic             r_valid;
      logic [W-1:0]     r_raw, r_corr;
      logic [LANES-1:0] r_sel;
      logic [TAGW-1:0]  r_tag;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_raw   <= '0;
          r_corr  <= '0;
          r_sel   <= '0;
          r_tag   <= '0;
        end else if (w_en) begin
          r_valid <= w_s0_valid;
          r_raw   <= w_add_raw;
          r_corr  <= w_add_corr;
          r_sel   <= w_add_sel;
          r_tag   <= w_s0_tag;
        end
      end
      assign w_s1_valid = r_valid;
      assign w_s1_raw   = r_raw;
      assign w_s1_corr  = r_corr;
      assign w_s1_sel   = r_sel;
      assign w_s1_tag   = r_tag;
    end else begin : g_no_ff_add
      assign w_s1_valid = w_s0_valid;
      assign w_s1_raw   = w_add_raw;
      assign w_s1_corr  = w_add_corr;
      assign w_s1_sel   = w_add_sel;
      assign w_s1_tag   = w_s0_tag;
    end

    if (FF_OUT != 0) begin : g_ff_out
      logic            r_valid;
      logic [W-1:0]    r_c;
      logic [TAGW-1:0] r_tag;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_c     <= '0;
          r_tag   <= '0;
        end else if (w_en) begin
          r_valid <= w_s1_valid;
          r_c     <= w_c;
          r_tag   <= w_s1_tag;
        end
      end
      assign out_valid = r_valid;
      assign out_c     = r_c;
      assign out_tag   = r_tag;
    end else begin : g_no_ff_out
      assign out_valid = w_s1_valid;
      assign out_c     = w_c;
      assign out_tag   = w_s1_tag;
    end
  endgenerate

endmodule

// File: tb/tb_modaddsub_pipe.sv
// tb/tb_modaddsub_pipe.sv - scoreboard bench: directed cases on an all-registered DUT plus a latency sweep
module tb_modaddsub_pipe;
  import modaddsub_pkg::*;

  localparam int LOGQ = 8;
  localparam int LANES = 2;
  localparam int TAGW = 8;
  localparam int W = LANES * LOGQ;
  localparam int Q = 251;
  localparam int M_LAT = 3;

  typedef struct {
    int     c0;
    int     c1;
    int     tag;
    longint enc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sweep_go = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_mod(input logic op, input int q, input int a, input int b);
    int r;
    if (op == 1'b0) begin
      r = a + b;
      if (r >= q) r = r - q;
    end else begin
      r = a - b;
      if (r < 0) r = r + q;
    end
    return r;
  endfunction

  logic            m_in_valid, m_in_ready, m_in_op, m_out_valid, m_out_ready;
  logic [LOGQ-1:0] m_in_q;
  logic [W-1:0]    m_in_a, m_in_b, m_out_c;
  logic [TAGW-1:0] m_in_tag, m_out_tag;

  modaddsub_pipe #(.LOGQ(LOGQ), .LANES(LANES), .TAGW(TAGW), .FF_IN(1), .FF_ADD(1), .FF_OUT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_op(m_in_op),
    .in_q(m_in_q), .in_a(m_in_a), .in_b(m_in_b), .in_tag(m_in_tag), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .out_c(m_out_c), .out_tag(m_out_tag)
  );

  exp_t            m_q[$];
  longint          m_enc = 0;
  logic            m_prev_stall = 1'b0;
  logic [W-1:0]    m_prev_c = '0;
  logic [TAGW-1:0] m_prev_tag = '0;

  always @(negedge clk) begin : m_mon
    exp_t e;
    if (rst) begin
      m_q.delete();
      m_prev_stall = 1'b0;
    end else begin
      if (m_prev_stall) begin
        chk("hold_valid", 64'(m_out_valid), 1);
        chk("hold_c", 64'(m_out_c), 64'(m_prev_c));
        chk("hold_tag", 64'(m_out_tag), 64'(m_prev_tag));
      end
      if (m_in_valid && m_in_ready) begin
        e.c0  = ref_mod(m_in_op, int'(m_in_q), int'(m_in_a[7:0]), int'(m_in_b[7:0]));
        e.c1  = ref_mod(m_in_op, int'(m_in_q), int'(m_in_a[15:8]), int'(m_in_b[15:8]));
        e.tag = int'(m_in_tag);
        e.enc = m_enc;
        m_q.push_back(e);
      end
      if (m_out_valid && m_out_ready) begin
        if (m_q.size() == 0) begin
          chk("main_spurious_out", 1, 0);
        end else begin
          e = m_q.pop_front();
          chk("main_c0", 64'(m_out_c[7:0]), 64'(e.c0));
          chk("main_c1", 64'(m_out_c[15:8]), 64'(e.c1));
          chk("main_tag", 64'(m_out_tag), 64'(e.tag));
          chk("main_lat", 64'(m_enc - e.enc), M_LAT);
        end
      end
      m_prev_stall = m_out_valid & ~m_out_ready;
      m_prev_c     = m_out_c;
      m_prev_tag   = m_out_tag;
      if (!m_out_valid || m_out_ready) m_enc++;
    end
  end

  generate
    for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int FI = (g == 1) ? 1 : 0;
      localparam int FA = (g == 2) ? 1 : 0;
      localparam int FO = (g == 1) ? 1 : 0;
      localparam stage_flags_t SF = '{ff_in: (FI != 0), ff_add: (FA != 0), ff_out: (FO != 0)};
      localparam int SLAT = modaddsub_lat(SF);

      logic            s_in_valid, s_in_ready, s_in_op, s_out_valid, s_out_ready;
      logic [LOGQ-1:0] s_in_q;
      logic [W-1:0]    s_in_a, s_in_b, s_out_c;
      logic [TAGW-1:0] s_in_tag, s_out_tag;
      logic            done = 1'b0;
      exp_t            s_q[$];
      longint          s_enc = 0;

      modaddsub_pipe #(.LOGQ(LOGQ), .LANES(LANES), .TAGW(TAGW), .FF_IN(FI), .FF_ADD(FA), .FF_OUT(FO)) u_dut (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
        .in_q(s_in_q), .in_a(s_in_a), .in_b(s_in_b), .in_tag(s_in_tag), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_c(s_out_c), .out_tag(s_out_tag)
      );

      initial begin : drv
        int qv;
        s_in_valid = 1'b0; s_in_op = 1'b0; s_in_q = 8'd2; s_in_a = '0; s_in_b = '0;
        s_in_tag = '0; s_out_ready = 1'b1;
        wait (sweep_go);
        for (int k = 0; k < 300; k++) begin
          @(posedge clk); #1;
          qv          = int'($urandom_range(255, 2));
          s_in_valid  = ($urandom_range(3) != 0);
          s_in_op     = 1'($urandom_range(1));
          s_in_q      = 8'(qv);
          s_in_a      = {8'($urandom_range(qv - 1)), 8'($urandom_range(qv - 1))};
          s_in_b      = {8'($urandom_range(qv - 1)), 8'($urandom_range(qv - 1))};
          s_in_tag    = 8'(k);
          s_out_ready = ($urandom_range(2) != 0);
        end
        @(posedge clk); #1;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk($sformatf("sweep%0d_drain", g), 64'(s_q.size()), 0);
        done = 1'b1;
      end

      always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
          s_q.delete();
        end else begin
          if (s_in_valid && s_in_ready) begin
            e.c0  = ref_mod(s_in_op, int'(s_in_q), int'(s_in_a[7:0]), int'(s_in_b[7:0]));
            e.c1  = ref_mod(s_in_op, int'(s_in_q), int'(s_in_a[15:8]), int'(s_in_b[15:8]));
            e.tag = int'(s_in_tag);
            e.enc = s_enc;
            s_q.push_back(e);
          end
          if (s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) begin
              chk($sformatf("sweep%0d_spurious_out", g), 1, 0);
            end else begin
              e = s_q.pop_front();
              chk($sformatf("sweep%0d_c0", g), 64'(s_out_c[7:0]), 64'(e.c0));
              chk($sformatf("sweep%0d_c1", g), 64'(s_out_c[15:8]), 64'(e.c1));
              chk($sformatf("sweep%0d_tag", g), 64'(s_out_tag), 64'(e.tag));
              chk($sformatf("sweep%0d_lat", g), 64'(s_enc - e.enc), 64'(SLAT));
            end
          end
          if (!s_out_valid || s_out_ready) s_enc++;
        end
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic op, input int a0, input int b0,
                       input int a1, input int b1, input int tag);
    m_in_valid = v;
    m_in_op    = op;
    m_in_a     = {8'(a1), 8'(a0)};
    m_in_b     = {8'(b1), 8'(b0)};
    m_in_tag   = 8'(tag);
  endtask

  task automatic lat_test(input string nm, input logic op, input int a0, input int b0,
                          input int a1, input int b1, input int tag, input int c0, input int c1);
    tick();
    drive(1'b1, op, a0, b0, a1, b1, tag);
    @(negedge clk);
    chk({nm, "_accept"}, 64'(m_in_ready), 1);
    for (int k = 1; k <= M_LAT; k++) begin
      tick();
      if (k == 1) drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk({nm, "_valid"}, 64'(m_out_valid), (k == M_LAT) ? 1 : 0);
    end
    chk({nm, "_c0"}, 64'(m_out_c[7:0]), 64'(c0));
    chk({nm, "_c1"}, 64'(m_out_c[15:8]), 64'(c1));
    chk({nm, "_tag"}, 64'(m_out_tag), 64'(tag));
  endtask

  initial begin : main
    int  sent, got, stall;
    logic seen, all_done;
    m_in_valid = 1'b0; m_in_op = 1'b0; m_in_q = 8'(Q); m_in_a = '0; m_in_b = '0;
    m_in_tag = '0; m_out_ready = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 64'(m_out_valid), 0);
    chk("rst_out_c", 64'(m_out_c), 0);
    chk("rst_out_tag", 64'(m_out_tag), 0);
    chk("rst_in_ready", 64'(m_in_ready), 1);
    tick();
    rst = 1'b0;

    lat_test("add", OP_ADD, 200, 100, 125, 126, 8'hA5, 49, 0);
    lat_test("sub", OP_SUB, 10, 20, 20, 10, 8'h21, 241, 10);

    for (int k = 0; k < 7; k++) begin
      tick();
      if (k < 4)
        drive(1'b1, (k % 2 == 1) ? OP_SUB : OP_ADD, int'($urandom_range(250)), int'($urandom_range(250)),
              int'($urandom_range(250)), int'($urandom_range(250)), k + 1);
      else
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (k < 4) chk("b2b_in_ready", 64'(m_in_ready), 1);
      if (k >= 3) begin
        chk("b2b_valid", 64'(m_out_valid), 1);
        chk("b2b_tag", 64'(m_out_tag), 64'(k - 2));
      end
    end

    sent = 0; got = 0; stall = 0; seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (sent < 6)
        drive(1'b1, 1'(sent % 2), int'($urandom_range(250)), int'($urandom_range(250)),
              int'($urandom_range(250)), int'($urandom_range(250)), 10 + sent);
      else
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
      m_out_ready = (stall == 0);
      @(negedge clk);
      if (stall > 0) begin
        chk("bp_in_ready", 64'(m_in_ready), 0);
        stall--;
      end
      if (m_in_valid && m_in_ready) sent++;
      if (m_out_valid && m_out_ready) begin
        got++;
        if (!seen) begin
          seen  = 1'b1;
          stall = 3;
        end
      end
    end
    m_out_ready = 1'b1;
    chk("bp_sent", 64'(sent), 6);
    chk("bp_got", 64'(got), 6);
    chk("bp_queue_empty", 64'(m_q.size()), 0);

    tick();
    drive(1'b1, OP_ADD, 1, 2, 3, 4, 8'h51);
    tick();
    drive(1'b1, OP_SUB, 5, 6, 7, 8, 8'h52);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    tick();
    chk("mid_pre_valid", 64'(m_out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(m_out_valid), 0);
    chk("mid_rst_c", 64'(m_out_c), 0);
    chk("mid_rst_in_ready", 64'(m_in_ready), 1);
    @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      chk("mid_no_stale", 64'(m_out_valid), 0);
    end
    lat_test("post_rst", OP_SUB, 0, 250, 250, 250, 8'h77, 1, 0);

    sweep_go = 1'b1;
    all_done = 1'b0;
    for (int k = 0; k < 2000 && !all_done; k++) begin
      @(posedge clk);
      all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done;
    end
    chk("sweep_finished", 64'(all_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
